// File: rtl/pid_scheduler_if.sv
// Avalon-MM style bus between the PID sweep scheduler and the muxed pid_controller slaves.
interface pid_scheduler_if #(
  parameter int NUM_CHANNELS = 4
);
  logic [NUM_CHANNELS-1:0] chipselect;
  logic [3:0]              address;
  logic                    write;
  logic                    read;
  logic [31:0]             writedata;
  logic [31:0]             readdata;
  logic                    waitrequest;

  modport master (
    output chipselect, address, write, read, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  chipselect, address, write, read, writedata,
    output readdata, waitrequest
  );
endinterface

// File: rtl/pid_scheduler.sv
// Periodically sweeps NUM_CHANNELS pid_controllers over Avalon: write setpoint, write
// process value, read the controller output, with per-transfer stall timeout.
module pid_scheduler #(
  parameter int NUM_CHANNELS   = 4,
  parameter int PERIOD_CYCLES  = 50000,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [32*NUM_CHANNELS-1:0] sp_in,
  input  logic [32*NUM_CHANNELS-1:0] pv_in,
  pid_scheduler_if.master           m,
  output logic [32*NUM_CHANNELS-1:0] result_out,
  output logic                      sweep_done,
  output logic                      overrun,
  output logic [NUM_CHANNELS-1:0]   timeout_err
);

  localparam int CNT_W   = $clog2(PERIOD_CYCLES);
  localparam int CH_W    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, WR_SP, WR_PV, RD_RES, NEXT} state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   period_cnt;
  logic [CH_W-1:0]    ch;
  logic [STALL_W-1:0] stall_cnt;
  logic [31:0]        sp_snap [NUM_CHANNELS];
  logic [31:0]        pv_snap [NUM_CHANNELS];
  logic [31:0]        result  [NUM_CHANNELS];

  logic tick;
  logic xfer;
  logic abort;
  logic last_ch;
  logic start;

  assign tick    = (period_cnt == CNT_W'(PERIOD_CYCLES - 1));
  assign xfer    = (state == WR_SP) || (state == WR_PV) || (state == RD_RES);
  assign abort   = xfer && m.waitrequest && (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1));
  assign last_ch = (ch == CH_W'(NUM_CHANNELS - 1));
  assign start   = (state == IDLE) && tick && enable;

  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_result
    assign result_out[32*k +: 32] = result[k];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      period_cnt <= '0;
    end else if (tick) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Bus outputs decode purely from state/ch/snapshots, so they hold still during a stall.
  always_comb begin
    state_next   = state;
    m.chipselect = '0;
    m.address    = 4'd0;
    m.write      = 1'b0;
    m.read       = 1'b0;
    m.writedata  = 32'd0;
    sweep_done   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = WR_SP;
      end
      WR_SP: begin
        m.chipselect = NUM_CHANNELS'(1) << ch;
        m.write      = 1'b1;
        m.address    = 4'd4;
        m.writedata  = sp_snap[ch];
        if (abort) state_next = NEXT;
        else if (!m.waitrequest) state_next = WR_PV;
      end
      WR_PV: begin
        m.chipselect = NUM_CHANNELS'(1) << ch;
        m.write      = 1'b1;
        m.address    = 4'd5;
        m.writedata  = pv_snap[ch];
        if (abort) state_next = NEXT;
        else if (!m.waitrequest) state_next = RD_RES;
      end
      RD_RES: begin
        m.chipselect = NUM_CHANNELS'(1) << ch;
        m.read       = 1'b1;
        m.address    = 4'd0;
        if (abort || !m.waitrequest) state_next = NEXT;
      end
      NEXT: begin
        sweep_done = last_ch;
        state_next = last_ch ? IDLE : WR_SP;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ch          <= '0;
      stall_cnt   <= '0;
      overrun     <= 1'b0;
      timeout_err <= '0;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        sp_snap[k] <= '0;
        pv_snap[k] <= '0;
        result[k]  <= '0;
      end
    end else begin
      if (start) begin
        ch <= '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
          sp_snap[k] <= sp_in[32*k +: 32];
          pv_snap[k] <= pv_in[32*k +: 32];
        end
      end else if (state == NEXT && !last_ch) begin
        ch <= ch + CH_W'(1);
      end

      if (xfer && m.waitrequest && !abort) stall_cnt <= stall_cnt + STALL_W'(1);
      else stall_cnt <= '0;

      if (abort) timeout_err[ch] <= 1'b1;
      if (state == RD_RES && !m.waitrequest) result[ch] <= m.readdata;

      // A tick while busy is dropped rather than queued.
      if (tick && state != IDLE) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pid_scheduler.sv
// Directed bench: instance A (period 20, timeout 10) covers sweeps, stalls, timeout and
// mid-transfer reset; instance B (period 6) covers overrun.
module tb_pid_scheduler;

  logic        clock;
  logic        rst_a_n, rst_b_n;
  logic        enable_a, enable_b;
  logic [63:0] sp_a, pv_a;
  logic [63:0] result_a, result_b;
  logic        sweep_done_a, sweep_done_b;
  logic        overrun_a, overrun_b;
  logic [1:0]  timeout_err_a, timeout_err_b;

  logic [31:0] rd0, rd1;
  logic        arm;
  logic [1:0]  stuck_mask;
  logic [1:0]  pv_stall;
  logic        pv_phase;

  int cyc;
  int tests_run;
  int failed;

  pid_scheduler_if #(.NUM_CHANNELS(2)) bus_a ();
  pid_scheduler_if #(.NUM_CHANNELS(2)) bus_b ();

  pid_scheduler #(.NUM_CHANNELS(2), .PERIOD_CYCLES(20), .TIMEOUT_CYCLES(10)) dut_a (
    .clock       (clock),
    .reset_n     (rst_a_n),
    .enable      (enable_a),
    .sp_in       (sp_a),
    .pv_in       (pv_a),
    .m           (bus_a),
    .result_out  (result_a),
    .sweep_done  (sweep_done_a),
    .overrun     (overrun_a),
    .timeout_err (timeout_err_a)
  );

  pid_scheduler #(.NUM_CHANNELS(2), .PERIOD_CYCLES(6), .TIMEOUT_CYCLES(10)) dut_b (
    .clock       (clock),
    .reset_n     (rst_b_n),
    .enable      (enable_b),
    .sp_in       ({32'd200, 32'd100}),
    .pv_in       ({32'd50, 32'd40}),
    .m           (bus_b),
    .result_out  (result_b),
    .sweep_done  (sweep_done_b),
    .overrun     (overrun_b),
    .timeout_err (timeout_err_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Slave model for A: per-channel read data, optional 3-cycle stall on ch1's PV write, optional stuck channels.
  assign pv_phase          = bus_a.chipselect[1] && bus_a.write && (bus_a.address == 4'd5);
  assign bus_a.readdata    = bus_a.chipselect[1] ? rd1 : rd0;
  assign bus_a.waitrequest = (arm && pv_phase && (pv_stall < 2'd3)) || (|(bus_a.chipselect & stuck_mask));

  always @(posedge clock or negedge rst_a_n) begin
    if (!rst_a_n) pv_stall <= 2'd0;
    else if (!pv_phase) pv_stall <= 2'd0;
    else if (arm && pv_stall < 2'd3) pv_stall <= pv_stall + 2'd1;
  end

  assign bus_b.readdata    = 32'd7;
  assign bus_b.waitrequest = 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    assert (observed === expected)
      else begin
        failed++;
        $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
  endtask

  task automatic applyStimulus(input logic en, input logic [63:0] sp, input logic [63:0] pv);
    enable_a = en;
    sp_a     = sp;
    pv_a     = pv;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  initial begin
    tests_run = 0;
    failed = 0;
    cyc = 0;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    enable_b = 1'b0;
    rd0 = 32'd60;
    rd1 = 32'd150;
    arm = 1'b0;
    stuck_mask = 2'b00;
    applyStimulus(1'b0, {32'd200, 32'd100}, {32'd50, 32'd40});
    repeat (3) @(negedge clock);

    checkOutput("rst_write", bus_a.write, 64'd0);
    checkOutput("rst_cs", bus_a.chipselect, 64'd0);
    checkOutput("rst_result", result_a, 64'd0);
    checkOutput("rst_flags", {overrun_a, sweep_done_a, timeout_err_a}, 64'd0);

    // Sweep 1: zero-wait slaves
    applyStimulus(1'b1, {32'd200, 32'd100}, {32'd50, 32'd40});
    rst_a_n = 1'b1;
    cyc = 0;
    run_to(19); checkOutput("idle_at_tick", {bus_a.write, bus_a.read}, 64'd0);
    run_to(20); checkOutput("s1_wrsp0", {bus_a.chipselect, bus_a.write, bus_a.read, bus_a.address, bus_a.writedata},
                            {2'b01, 1'b1, 1'b0, 4'd4, 32'd100});
    run_to(21); checkOutput("s1_wrpv0", {bus_a.address, bus_a.writedata}, {4'd5, 32'd40});
    run_to(22); checkOutput("s1_rd0", {bus_a.chipselect, bus_a.write, bus_a.read, bus_a.address}, {2'b01, 1'b0, 1'b1, 4'd0});
    run_to(23); checkOutput("s1_next0", {bus_a.chipselect, bus_a.write, bus_a.read}, 64'd0);
    run_to(24); checkOutput("s1_wrsp1", {bus_a.chipselect, bus_a.address, bus_a.writedata}, {2'b10, 4'd4, 32'd200});
    run_to(25); checkOutput("s1_wrpv1", {bus_a.address, bus_a.writedata}, {4'd5, 32'd50});
    run_to(26); checkOutput("s1_rd1", {bus_a.chipselect, bus_a.read, sweep_done_a}, {2'b10, 1'b1, 1'b0});
    run_to(27); checkOutput("s1_done", sweep_done_a, 64'd1);
    checkOutput("s1_result", result_a, {32'd150, 32'd60});
    run_to(28); checkOutput("s1_done_pulse", sweep_done_a, 64'd0);

    // Sweep 2: ch1 PV write stalls 3 cycles
    rd0 = 32'd61;
    rd1 = 32'd151;
    arm = 1'b1;
    run_to(44); checkOutput("s2_wrsp1", {bus_a.chipselect, bus_a.write, bus_a.address}, {2'b10, 1'b1, 4'd4});
    for (int c = 45; c <= 48; c++) begin
      run_to(c);
      checkOutput("s2_stall_bus", {bus_a.chipselect, bus_a.write, bus_a.read, bus_a.address, bus_a.writedata},
                  {2'b10, 1'b1, 1'b0, 4'd5, 32'd50});
      checkOutput("s2_stall_wait", bus_a.waitrequest, (c < 48) ? 64'd1 : 64'd0);
    end
    run_to(49); checkOutput("s2_rd1", {bus_a.read, sweep_done_a}, {1'b1, 1'b0});
    run_to(50); checkOutput("s2_done", sweep_done_a, 64'd1);
    checkOutput("s2_no_err", timeout_err_a, 64'd0);
    checkOutput("s2_result", result_a, {32'd151, 32'd61});
    arm = 1'b0;

    // Sweep 3: ch0 stuck, aborts after 10 stall cycles
    stuck_mask = 2'b01;
    rd0 = 32'd99;
    rd1 = 32'd152;
    run_to(60); checkOutput("s3_wrsp0", {bus_a.chipselect, bus_a.write}, {2'b01, 1'b1});
    run_to(69); checkOutput("s3_last_stall", {bus_a.write, bus_a.address, timeout_err_a}, {1'b1, 4'd4, 2'b00});
    run_to(70); checkOutput("s3_abort", {bus_a.chipselect, bus_a.write, timeout_err_a}, {2'b00, 1'b0, 2'b01});
    run_to(71); checkOutput("s3_wrsp1", {bus_a.chipselect, bus_a.write, bus_a.address}, {2'b10, 1'b1, 4'd4});
    run_to(74); checkOutput("s3_done", sweep_done_a, 64'd1);
    run_to(75); checkOutput("s3_result", result_a, {32'd152, 32'd61});
    checkOutput("s3_err_sticky", timeout_err_a, 64'd1);
    checkOutput("a_no_overrun", overrun_a, 64'd0);
    stuck_mask = 2'b00;

    // Sweep 4: reset pulled low during RD_RES of ch0
    run_to(82); checkOutput("s4_rd0", {bus_a.chipselect, bus_a.read}, {2'b01, 1'b1});
    rst_a_n = 1'b0;
    #1;
    checkOutput("rst_mid_bus", {bus_a.chipselect, bus_a.read, bus_a.write}, 64'd0);
    checkOutput("rst_mid_state", {result_a, timeout_err_a, sweep_done_a}, 64'd0);
    @(negedge clock);
    applyStimulus(1'b1, {32'd300, 32'd110}, {32'd70, 32'd80});
    rst_a_n = 1'b1;
    cyc = 0;
    run_to(19); checkOutput("post_rst_idle", bus_a.write, 64'd0);
    run_to(20); checkOutput("post_rst_wrsp0", {bus_a.chipselect, bus_a.write, bus_a.writedata}, {2'b01, 1'b1, 32'd110});
    run_to(21); checkOutput("post_rst_wrpv0", bus_a.writedata, 64'd80);
    applyStimulus(1'b0, {32'd999, 32'd110}, {32'd70, 32'd80});
    run_to(24); checkOutput("snapshot_sp1", bus_a.writedata, 64'd300);
    run_to(27); checkOutput("enable_low_done", sweep_done_a, 64'd1);
    run_to(28); checkOutput("post_rst_result", result_a, {32'd152, 32'd99});
    run_to(40); checkOutput("enable_blocks", {bus_a.write, overrun_a}, 64'd0);

    // Instance B: 8-cycle sweep against a 6-cycle period
    @(negedge clock);
    rst_b_n = 1'b1;
    enable_b = 1'b1;
    cyc = 0;
    run_to(5);  checkOutput("b_idle", {bus_b.write, overrun_b}, 64'd0);
    run_to(6);  checkOutput("b_start", {bus_b.chipselect, bus_b.write}, {2'b01, 1'b1});
    run_to(11); checkOutput("b_tick2_before", overrun_b, 64'd0);
    run_to(12); checkOutput("b_overrun", overrun_b, 64'd1);
    run_to(13); checkOutput("b_done", sweep_done_b, 64'd1);
    run_to(14); checkOutput("b_no_b2b", {bus_b.chipselect, bus_b.write, bus_b.read}, 64'd0);
    checkOutput("b_result", result_b, {32'd7, 32'd7});
    run_to(17); checkOutput("b_wait_tick3", bus_b.write, 64'd0);
    run_to(18); checkOutput("b_tick3_start", {bus_b.chipselect, bus_b.write, overrun_b}, {2'b01, 1'b1, 1'b1});

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
